cnn_layer_sequencer: RTL and testbench
======================================

Name: cnn_layer_sequencer

Overview:
Top-level scheduler for the CNN inference pipeline (conv2d → relu → maxpool → dense).
- Accepts a frame-start request once the input feature map is loaded into IFMAP BRAM.
- Launches each layer in order with a one-cycle start pulse and waits for that layer's done pulse.
- Drives the buffer-ownership select used by the BRAM port muxes.
- Guards every layer with a watchdog and reports completion or error.

Parameters:
- N_STAGES, 4, number of sequenced layers; stage index 0 runs first.
- TIMEOUT_CYCLES, 262143, max cycles a stage may run before abort; 0 disables the watchdog.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to run one frame; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- stage_start  out  N_STAGES  one-hot, one-cycle launch pulse per stage.
- stage_done  in  N_STAGES  per-stage one-cycle completion pulses.
- stage_abort  out  N_STAGES  one-cycle pulse to the timed-out stage.
- buf_sel  out  $clog2(N_STAGES)  index of the stage that currently owns the shared BRAM ports.
- seq_done  out  1  one-cycle pulse when the frame finishes, successfully or with error.
- err  out  1  sticky timeout flag.
- err_stage  out  $clog2(N_STAGES)  index of the stage that timed out.
- perf_cycles  out  N_STAGES*CNT_W  per-stage cycle counts; stage i occupies bits [i*CNT_W +: CNT_W].
- total_cycles  out  CNT_W  cycle count for the whole frame.

Behaviour:
Clock and reset:
- Single clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset values: state=IDLE; busy, stage_start, stage_abort, seq_done, err all 0; buf_sel=0; err_stage=0; counters 0.
- Reset mid-run returns to IDLE next edge and emits no pulses.

States: IDLE, WAIT, ADVANCE, FINISH, ABORT.

IDLE:
- On start=1 at edge t: clear err/err_stage, set idx=0, buf_sel=0, stage_start[0]=1 during cycle t+1, busy=1, go to WAIT, clear timer.
- start in any other state is ignored.

WAIT:
- stage_done[idx] is ignored while stage_start[idx] is high, i.e. in the launch cycle.
- After that, stage_done[idx]=1 at edge t:
  - If idx<N_STAGES-1: go to ADVANCE.
  - Else: go to FINISH.
- stage_done bits for any stage other than idx are ignored.
- If stage_done[idx] and the timer expiry occur on the same edge, done wins.
- Timer increments every WAIT cycle. When TIMEOUT_CYCLES≠0 and timer==TIMEOUT_CYCLES-1 without done: go to ABORT.

ADVANCE (one cycle):
- idx and buf_sel increment.
- stage_start[idx+1] is high in the following cycle; state returns to WAIT; timer clears.
- Stage-to-stage gap: done at edge t gives the next start high in cycle t+2.

FINISH (one cycle):
- seq_done=1 and busy=0 on the next cycle; go to IDLE.
- buf_sel holds its last value.

ABORT (one cycle):
- stage_abort[idx]=1, err=1, err_stage=idx, seq_done=1; go to IDLE.
- Remaining stages are skipped.

Arithmetic: timer width is $clog2(TIMEOUT_CYCLES+1), minimum 1; no wrap is possible before expiry.

Optional Feature:
Macro SEQ_PERF_COUNT_EN.
- Defined:
  - perf_cycles[i] counts WAIT cycles of stage i, including the launch cycle.
  - total_cycles counts from start acceptance to seq_done inclusive.
  - Both clear on start acceptance and saturate at all-ones.
  - Values hold after the frame until the next start.
- Not defined: perf_cycles and total_cycles tie to 0; no counter logic is synthesised.

Decomposition:
- Package cnn_seq_pkg holds:
  - seq_state_t enum.
  - Stage index constants STG_CONV=0, STG_RELU=1, STG_POOL=2, STG_DENSE=3.
  - Helper function clog2_min1.
- Sub-module seq_watchdog contains the timer, with clear/enable/expired ports and parameter TIMEOUT_CYCLES.

Test Plan:
- Nominal run: start pulse; stages answer done 5, 3, 7, 2 cycles after their start → stage_start pulses in order, each 2 cycles after the prior done; buf_sel goes 0,1,2,3; a single seq_done; err=0.
- Timeout: TIMEOUT_CYCLES=10, stage 1 never finishes → stage_abort=4'b0010 exactly 10 WAIT cycles after launch; err=1; err_stage=1; seq_done=1; stages 2–3 never started.
- Done/expiry collision: stage 0 done on the exact expiry cycle → normal advance, err=0.
- Spurious inputs: start held high during a run, plus stage_done[3] pulsed while idx=0 → no restart, no skip; a run completes normally.
- Reset mid-stage-2: assert reset for 1 cycle → next cycle all outputs at reset values, no seq_done; a fresh start then runs cleanly.
- SEQ_PERF_COUNT_EN: stage durations 5,3,7,2 → perf_cycles = 6,4,8,3; total_cycles = 25.

Source files
------------

// File: rtl/cnn_seq_pkg.sv
// Shared types and constants for the CNN layer sequencer.
package cnn_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ADVANCE,
    FINISH,
    ABORT
  } seq_state_t;

  localparam int STG_CONV  = 0;
  localparam int STG_RELU  = 1;
  localparam int STG_POOL  = 2;
  localparam int STG_DENSE = 3;

  // Bit width needed to hold values below 'value', never less than one bit.
  function automatic int clog2_min1(input int unsigned value);
    int r;
    r = $clog2(value);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-stage watchdog: counts enabled cycles and flags the cycle on which the
// stage has used its whole budget. TIMEOUT_CYCLES = 0 disables the flag.
module seq_watchdog
  import cnn_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 262143
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int          TW    = clog2_min1(TIMEOUT_CYCLES + 1);
  localparam int unsigned LIM   = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [TW-1:0] LIMIT = TW'(LIM);

  logic [TW-1:0] timer;

  // Cycle counter; clear has priority, saturates so a disabled watchdog never wraps.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      timer <= '0;
    end else if (enable && (timer != '1)) begin
      timer <= timer + TW'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && enable && (timer == LIMIT);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Frame scheduler for the conv2d -> relu -> maxpool -> dense pipeline.
// Launches each stage in turn, waits for its done pulse under a watchdog,
// and owns the BRAM port select. Optional per-stage and per-frame cycle
// counters are built when SEQ_PERF_COUNT_EN is defined.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; outputs hold last frame's buf_sel / err
// WAIT    | stage idx running; first cycle is the launch cycle
// ADVANCE | one-cycle gap before launching stage idx+1
// FINISH  | last stage done; seq_done high, busy low
// ABORT   | stage idx timed out; abort pulse, err, seq_done high
module cnn_layer_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int          N_STAGES       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 262143,
  parameter int          CNT_W          = 32,
  localparam int         IW             = clog2_min1(N_STAGES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic [N_STAGES-1:0]       stage_start,
  input  logic [N_STAGES-1:0]       stage_done,
  output logic [N_STAGES-1:0]       stage_abort,
  output logic [IW-1:0]             buf_sel,
  output logic                      seq_done,
  output logic                      err,
  output logic [IW-1:0]             err_stage,
  output logic [N_STAGES*CNT_W-1:0] perf_cycles,
  output logic [CNT_W-1:0]          total_cycles
);

  seq_state_t          state, state_nxt;
  logic [IW-1:0]       idx, idx_nxt, idx_inc;
  logic [IW-1:0]       buf_sel_nxt, err_stage_nxt;
  logic [N_STAGES-1:0] stage_start_nxt, stage_abort_nxt;
  logic                busy_nxt, seq_done_nxt, err_nxt;
  logic                done_hit, expired;

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != WAIT),
    .enable (state == WAIT),
    .expired(expired)
  );

  // Done from the running stage counts only after its launch cycle.
  assign done_hit = stage_done[idx] && !stage_start[idx];
  assign idx_inc  = idx + IW'(1);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      buf_sel     <= '0;
      busy        <= 1'b0;
      stage_start <= '0;
      stage_abort <= '0;
      seq_done    <= 1'b0;
      err         <= 1'b0;
      err_stage   <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      buf_sel     <= buf_sel_nxt;
      busy        <= busy_nxt;
      stage_start <= stage_start_nxt;
      stage_abort <= stage_abort_nxt;
      seq_done    <= seq_done_nxt;
      err         <= err_nxt;
      err_stage   <= err_stage_nxt;
    end
  end

  // Next state and next output values; pulses default low every cycle.
  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    buf_sel_nxt     = buf_sel;
    busy_nxt        = busy;
    stage_start_nxt = '0;
    stage_abort_nxt = '0;
    seq_done_nxt    = 1'b0;
    err_nxt         = err;
    err_stage_nxt   = err_stage;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt          = WAIT;
          idx_nxt            = '0;
          buf_sel_nxt        = '0;
          busy_nxt           = 1'b1;
          stage_start_nxt[0] = 1'b1;
          err_nxt            = 1'b0;
          err_stage_nxt      = '0;
        end
      end
      WAIT: begin
        // Done beats a same-edge expiry.
        if (done_hit) begin
          if (idx == IW'(N_STAGES - 1)) begin
            state_nxt    = FINISH;
            busy_nxt     = 1'b0;
            seq_done_nxt = 1'b1;
          end else begin
            state_nxt = ADVANCE;
          end
        end else if (expired) begin
          state_nxt            = ABORT;
          stage_abort_nxt[idx] = 1'b1;
          err_nxt              = 1'b1;
          err_stage_nxt        = idx;
          seq_done_nxt         = 1'b1;
          busy_nxt             = 1'b0;
        end
      end
      ADVANCE: begin
        state_nxt                = WAIT;
        idx_nxt                  = idx_inc;
        buf_sel_nxt              = idx_inc;
        stage_start_nxt[idx_inc] = 1'b1;
      end
      FINISH:  state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SEQ_PERF_COUNT_EN
  logic [N_STAGES-1:0][CNT_W-1:0] perf_q;
  logic [CNT_W-1:0]               total_q;

  // Saturating counters: stage counters tick in WAIT, frame counter in every
  // non-idle cycle (through the seq_done cycle); both clear on acceptance.
  always_ff @(posedge clk) begin
    if (reset || ((state == IDLE) && start)) begin
      perf_q  <= '0;
      total_q <= '0;
    end else begin
      if ((state != IDLE) && (total_q != '1)) begin
        total_q <= total_q + CNT_W'(1);
      end
      if ((state == WAIT) && (perf_q[idx] != '1)) begin
        perf_q[idx] <= perf_q[idx] + CNT_W'(1);
      end
    end
  end

  assign perf_cycles  = perf_q;
  assign total_cycles = total_q;
`else
  assign perf_cycles  = '0;
  assign total_cycles = '0;
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench for cnn_layer_sequencer (TIMEOUT_CYCLES = 10).
// Expected waveforms are built per frame from a stage-duration schedule.
module tb_cnn_layer_sequencer;
  import cnn_seq_pkg::*;

  localparam int N     = 4;
  localparam int T     = 10;
  localparam int CW    = 32;
  localparam int MAXC  = 64;
  localparam int NEVER = 1000;

  logic            clk = 1'b0;
  logic            reset, start;
  logic [N-1:0]    stage_done;
  logic            busy, seq_done, err;
  logic [N-1:0]    stage_start, stage_abort;
  logic [1:0]      buf_sel, err_stage;
  logic [N*CW-1:0] perf_cycles;
  logic [CW-1:0]   total_cycles;

  always #5 clk = ~clk;

  cnn_layer_sequencer #(
    .N_STAGES(N), .TIMEOUT_CYCLES(T), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .stage_start(stage_start), .stage_done(stage_done), .stage_abort(stage_abort),
    .buf_sel(buf_sel), .seq_done(seq_done), .err(err), .err_stage(err_stage),
    .perf_cycles(perf_cycles), .total_cycles(total_cycles)
  );

  int checks = 0;
  int errors = 0;

  logic [N-1:0] exp_start [MAXC];
  logic [N-1:0] exp_abort [MAXC];
  logic [N-1:0] drv_done  [MAXC];
  logic         exp_busy  [MAXC];
  logic         exp_sdone [MAXC];
  logic         exp_err   [MAXC];
  logic         drv_start [MAXC];
  logic         drv_reset [MAXC];
  logic [1:0]   exp_bsel  [MAXC];
  logic [1:0]   exp_estg  [MAXC];
  logic [CW-1:0] exp_perf [N];
  logic [CW-1:0] exp_total;

  int           rel = 0;
  logic         chk_en = 1'b0;
  int           seen_done_rel, seen_abort_rel;
  logic [N-1:0] seen_abort_val;
  logic [1:0]   prev_bsel = '0;
  logic         prev_err = 1'b0;
  logic [1:0]   prev_estg = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s rel=%0d got=%0h want=%0h", name, rel, act, want);
    end
  endtask

  // Per-cycle comparison of every control output against the schedule.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      check("busy",        busy,        exp_busy[rel]);
      check("stage_start", stage_start, exp_start[rel]);
      check("stage_abort", stage_abort, exp_abort[rel]);
      check("buf_sel",     buf_sel,     exp_bsel[rel]);
      check("seq_done",    seq_done,    exp_sdone[rel]);
      check("err",         err,         exp_err[rel]);
      check("err_stage",   err_stage,   exp_estg[rel]);
      if (seq_done === 1'b1 && seen_done_rel < 0) seen_done_rel = rel;
      if (stage_abort !== '0 && seen_abort_rel < 0) begin
        seen_abort_rel = rel;
        seen_abort_val = stage_abort;
      end
    end
  end

  // Cycle 0 is the cycle start is presented; stage i launched at s finishes
  // d cycles later (d < T), next launch two cycles after done; otherwise it
  // aborts T cycles after launch.
  task automatic run_frame(input int d0, input int d1, input int d2, input int d3,
                           input bit hold_start, input int rst_rel,
                           input logic [N-1:0] spur1, input logic [N-1:0] spur3);
    int d[N];
    int s, stop, len;
    d = '{d0, d1, d2, d3};
    for (int c = 0; c < MAXC; c++) begin
      exp_start[c] = '0; exp_abort[c] = '0; drv_done[c] = '0;
      exp_busy[c]  = 1'b0; exp_sdone[c] = 1'b0;
      exp_err[c]   = (c == 0) ? prev_err  : 1'b0;
      exp_estg[c]  = (c == 0) ? prev_estg : 2'd0;
      exp_bsel[c]  = (c == 0) ? prev_bsel : 2'd0;
      drv_start[c] = 1'b0; drv_reset[c] = 1'b0;
    end
    for (int i = 0; i < N; i++) exp_perf[i] = '0;
    s = 1;
    stop = 0;
    for (int i = 0; i < N && stop == 0; i++) begin
      exp_start[s][i] = 1'b1;
      for (int c = s; c < MAXC; c++) exp_bsel[c] = 2'(i);
      if (d[i] <= T - 1) begin
        drv_done[s + d[i]][i] = 1'b1;
        exp_perf[i] = CW'(d[i] + 1);
        if (i == N - 1) begin
          stop = s + d[i] + 1;
          exp_sdone[stop] = 1'b1;
        end else begin
          s = s + d[i] + 2;
        end
      end else begin
        stop = s + T;
        exp_abort[stop][i] = 1'b1;
        exp_sdone[stop] = 1'b1;
        exp_perf[i] = CW'(T);
        for (int c = stop; c < MAXC; c++) begin
          exp_err[c]  = 1'b1;
          exp_estg[c] = 2'(i);
        end
      end
    end
    for (int c = 1; c < stop; c++) exp_busy[c] = 1'b1;
    exp_total = CW'(stop);
    len = stop + 4;
    drv_start[0] = 1'b1;
    if (hold_start) for (int c = 0; c <= stop; c++) drv_start[c] = 1'b1;
    drv_done[1] = drv_done[1] | spur1;
    drv_done[3] = drv_done[3] | spur3;
    if (rst_rel >= 0) begin
      drv_reset[rst_rel] = 1'b1;
      for (int c = rst_rel + 1; c < MAXC; c++) begin
        exp_start[c] = '0; exp_abort[c] = '0; drv_done[c] = '0;
        exp_busy[c] = 1'b0; exp_sdone[c] = 1'b0; exp_err[c] = 1'b0;
        exp_estg[c] = 2'd0; exp_bsel[c] = 2'd0; drv_start[c] = 1'b0;
      end
      for (int i = 0; i < N; i++) exp_perf[i] = '0;
      exp_total = '0;
      len = rst_rel + 4;
    end

    seen_done_rel  = -1;
    seen_abort_rel = -1;
    seen_abort_val = '0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      rel        = c;
      start      = drv_start[c];
      stage_done = drv_done[c];
      reset      = drv_reset[c];
      chk_en     = 1'b1;
    end
    @(negedge clk);
    chk_en = 1'b0;
    start = 1'b0; stage_done = '0; reset = 1'b0;
    #2;
`ifdef SEQ_PERF_COUNT_EN
    for (int i = 0; i < N; i++) check("perf_cycles", perf_cycles[i*CW +: CW], exp_perf[i]);
    check("total_cycles", total_cycles, exp_total);
`else
    for (int i = 0; i < N; i++) check("perf_cycles", perf_cycles[i*CW +: CW], '0);
    check("total_cycles", total_cycles, '0);
`endif
    prev_bsel = exp_bsel[len - 1];
    prev_err  = exp_err[len - 1];
    prev_estg = exp_estg[len - 1];
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout rel=%0d", rel);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; stage_done = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy",        busy,         0);
    check("rst_stage_start", stage_start,  0);
    check("rst_stage_abort", stage_abort,  0);
    check("rst_buf_sel",     buf_sel,      0);
    check("rst_seq_done",    seq_done,     0);
    check("rst_err",         err,          0);
    check("rst_err_stage",   err_stage,    0);
    check("rst_total",       total_cycles, 0);

    // Nominal 5,3,7,2: seq_done lands on cycle 25.
    run_frame(5, 3, 7, 2, 1'b0, -1, '0, '0);
    check("nominal_done_cycle", seen_done_rel, 25);

    // Stage 1 hangs: launched cycle 5, aborted cycle 15.
    run_frame(2, NEVER, 1, 1, 1'b0, -1, '0, '0);
    check("timeout_abort_cycle", seen_abort_rel, 15);
    check("timeout_abort_val",   seen_abort_val, 4'b0010);
    check("timeout_err",         err,            1);
    check("timeout_err_stage",   err_stage,      1);

    // Stage 0 done on its expiry cycle.
    run_frame(9, 1, 1, 1, 1'b0, -1, '0, '0);
    check("collision_err", err, 0);

    // start held high, stage0 done in launch cycle, stage3 done while idx=0.
    run_frame(4, 2, 3, 1, 1'b1, -1, 4'b0001, 4'b1000);
    check("spurious_done_cycle", seen_done_rel, 18);

    // Reset during stage 2.
    run_frame(3, 3, 5, 2, 1'b0, 13, '0, '0);
    check("reset_no_seq_done", seen_done_rel, -1);

    // Fresh frame after reset.
    run_frame(5, 3, 7, 2, 1'b0, -1, '0, '0);
    check("rerun_done_cycle", seen_done_rel, 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
